// File: rtl/pipe_stall_ctrl.sv
// Pipeline stall/flush/freeze controller with a sticky DMEM watchdog.
// Optional perf counters are built only when PIPE_PERF_CNT_EN is defined.
module pipe_stall_ctrl #(
   parameter int WDOG_W   = 8,
   parameter int WDOG_MAX = 200,
   parameter int CNT_W    = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             lu_stall_req,
   input  logic             br_flush_req,
   input  logic             imem_busy,
   input  logic             dmem_busy,
   output logic             pc_en,
   output logic             if_id_en,
   output logic             if_id_flush,
   output logic             id_ex_en,
   output logic             id_ex_bubble,
   output logic             ex_mem_en,
   output logic             mem_wb_en,
   output logic [1:0]       state_o,
   output logic             err_wdog,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   // state    | meaning
   // RUN      | normal flow (also used for an IMEM-only bubble cycle)
   // LU_STALL | load-use bubble inserted into ID/EX
   // FREEZE   | DMEM busy, whole pipe held
   // FLUSH    | taken branch squashes IF/ID and ID/EX
   typedef enum logic [1:0] {
      S_RUN    = 2'd0,
      S_LU     = 2'd1,
      S_FREEZE = 2'd2,
      S_FLUSH  = 2'd3
   } state_t;

   localparam logic [WDOG_W-1:0] WDOG_LIM = WDOG_W'(WDOG_MAX);

   state_t            state, state_next;
   logic [WDOG_W-1:0] wdog_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_RUN;
      else        state <= state_next;
   end

   always_comb begin
      state_next   = S_RUN;
      pc_en        = 1'b1;
      if_id_en     = 1'b1;
      if_id_flush  = 1'b0;
      id_ex_en     = 1'b1;
      id_ex_bubble = 1'b0;
      ex_mem_en    = 1'b1;
      mem_wb_en    = 1'b1;
      if (rst_n) begin
         if (dmem_busy) begin
            state_next = S_FREEZE;
            pc_en      = 1'b0;
            if_id_en   = 1'b0;
            id_ex_en   = 1'b0;
            ex_mem_en  = 1'b0;
            mem_wb_en  = 1'b0;
         end else if (br_flush_req) begin
            // wrong-path instruction in ID makes any load-use stall moot
            state_next   = S_FLUSH;
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
         end else if (lu_stall_req) begin
            state_next   = S_LU;
            pc_en        = 1'b0;
            if_id_en     = 1'b0;
            id_ex_bubble = 1'b1;
         end else if (imem_busy) begin
            pc_en       = 1'b0;
            if_id_flush = 1'b1;
         end
      end
   end

   assign state_o = state;

   // Consecutive DMEM-busy cycles; saturates so err_wdog stays meaningful.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wdog_cnt <= '0;
         err_wdog <= 1'b0;
      end else if (!dmem_busy) begin
         wdog_cnt <= '0;
      end else if (wdog_cnt != WDOG_LIM) begin
         wdog_cnt <= wdog_cnt + 1'b1;
         if (wdog_cnt + 1'b1 == WDOG_LIM) err_wdog <= 1'b1;
      end
   end

`ifdef PIPE_PERF_CNT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else begin
         if (!pc_en)                 stall_cnt <= stall_cnt + 1'b1;
         if (state_next == S_FLUSH)  flush_cnt <= flush_cnt + 1'b1;
      end
   end
`else
   assign stall_cnt = '0;
   assign flush_cnt = '0;
`endif

endmodule
